// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the SRAM arbiter: FSM states, owner codes, strobe
// idle level and the pipeline bubble destination.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRd,
        StWr,
        StWrHold
    } arb_state_e;

    typedef enum logic {
        OwnerIf,
        OwnerMem
    } owner_e;

    // Active-low SRAM strobes rest high.
    localparam logic StrobeIdle = 1'b1;

    // Destination register code the hazard unit uses for a bubble in MEM/WB.
    localparam logic [3:0] RegNone = 4'b1111;

    // Counter width large enough to hold the longer of the two wait lengths.
    function automatic int unsigned cnt_width(input int unsigned rd_wait,
                                              input int unsigned wr_wait);
        return $clog2(((rd_wait > wr_wait) ? rd_wait : wr_wait) + 1);
    endfunction

endpackage

// File: rtl/mem_arbiter_wait_timer.sv
// Load/decrement wait counter; done while the count sits at one.
module mem_arbiter_wait_timer #(
    parameter int unsigned CntW = 2
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            load_i,
    input  logic [CntW-1:0] load_val_i,
    input  logic            dec_i,
    output logic            done_o
);

    logic [CntW-1:0] cnt_q;

    // Load on accept, count down while strobing, stop at one (never wraps).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q > CntW'(1))) begin
            cnt_q <= cnt_q - CntW'(1);
        end
    end

    assign done_o = (cnt_q == CntW'(1));

endmodule

// File: rtl/mem_arbiter.sv
// Shares one SRAM between instruction fetch and the MEM stage. Sequences the
// read/write strobes, returns data with a one-cycle ack and stalls requesters.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned DataW  = 16,
    parameter int unsigned AddrW  = 16,
    parameter int unsigned RdWait = 2,
    parameter int unsigned WrWait = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             if_req_i,
    input  logic [AddrW-1:0] if_addr_i,
    output logic [DataW-1:0] if_data_o,
    output logic             if_ack_o,
    output logic             if_stall_o,
    input  logic             mem_rd_req_i,
    input  logic             mem_wr_req_i,
    input  logic [AddrW-1:0] mem_addr_i,
    input  logic [DataW-1:0] mem_wdata_i,
    output logic [DataW-1:0] mem_rdata_o,
    output logic             mem_ack_o,
    output logic             mem_stall_o,
    output logic [AddrW-1:0] sram_addr_o,
    output logic [DataW-1:0] sram_dout_o,
    output logic             sram_doe_o,
    input  logic [DataW-1:0] sram_din_i,
    output logic             sram_ce_n_o,
    output logic             sram_oe_n_o,
    output logic             sram_we_n_o
);

    localparam int unsigned CntW = cnt_width(RdWait, WrWait);

    arb_state_e       state_q;
    owner_e           owner_q;
    logic [AddrW-1:0] sram_addr_q;
    logic [DataW-1:0] sram_dout_q;
    logic             sram_doe_q;
    logic             ce_n_q;
    logic             oe_n_q;
    logic             we_n_q;
    logic             if_ack_q;
    logic             mem_ack_q;
    logic [DataW-1:0] if_data_q;
    logic [DataW-1:0] mem_rdata_q;

    logic            acc_wr;
    logic            acc_rd;
    logic            acc_if;
    logic            timer_done;
    logic [CntW-1:0] timer_val;

    // Accept decode in IDLE: write > read > fetch; a request in its ack cycle is ignored.
    always_comb begin
        acc_wr = 1'b0;
        acc_rd = 1'b0;
        acc_if = 1'b0;
        if (state_q == StIdle) begin
            if (mem_wr_req_i && !mem_ack_q) begin
                acc_wr = 1'b1;
            end else if (mem_rd_req_i && !mem_ack_q) begin
                acc_rd = 1'b1;
            end else if (if_req_i && !if_ack_q) begin
                acc_if = 1'b1;
            end
        end
    end

    assign timer_val = acc_wr ? CntW'(WrWait) : CntW'(RdWait);

    mem_arbiter_wait_timer #(
        .CntW (CntW)
    ) u_wait_timer (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (acc_wr || acc_rd || acc_if),
        .load_val_i (timer_val),
        .dec_i      ((state_q == StRd) || (state_q == StWr)),
        .done_o     (timer_done)
    );

    // Access FSM with registered strobes, acks and returned data.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            owner_q     <= OwnerIf;
            sram_addr_q <= '0;
            sram_dout_q <= '0;
            sram_doe_q  <= 1'b0;
            ce_n_q      <= StrobeIdle;
            oe_n_q      <= StrobeIdle;
            we_n_q      <= StrobeIdle;
            if_ack_q    <= 1'b0;
            mem_ack_q   <= 1'b0;
            if_data_q   <= '0;
            mem_rdata_q <= '0;
        end else begin
            if_ack_q  <= 1'b0;
            mem_ack_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (acc_wr) begin
                        state_q     <= StWr;
                        owner_q     <= OwnerMem;
                        sram_addr_q <= mem_addr_i;
                        sram_dout_q <= mem_wdata_i;
                        sram_doe_q  <= 1'b1;
                        ce_n_q      <= 1'b0;
                        we_n_q      <= 1'b0;
                    end else if (acc_rd || acc_if) begin
                        state_q     <= StRd;
                        owner_q     <= acc_rd ? OwnerMem : OwnerIf;
                        sram_addr_q <= acc_rd ? mem_addr_i : if_addr_i;
                        ce_n_q      <= 1'b0;
                        oe_n_q      <= 1'b0;
                    end
                end
                StRd: begin
                    if (timer_done) begin
                        if (owner_q == OwnerMem) begin
                            mem_rdata_q <= sram_din_i;
                            mem_ack_q   <= 1'b1;
                        end else begin
                            if_data_q <= sram_din_i;
                            if_ack_q  <= 1'b1;
                        end
                        ce_n_q  <= StrobeIdle;
                        oe_n_q  <= StrobeIdle;
                        state_q <= StIdle;
                    end
                end
                StWr: begin
                    // Release we_n first; keep the bus driven one more cycle for data hold.
                    if (timer_done) begin
                        we_n_q  <= StrobeIdle;
                        state_q <= StWrHold;
                    end
                end
                StWrHold: begin
                    mem_ack_q  <= 1'b1;
                    sram_doe_q <= 1'b0;
                    ce_n_q     <= StrobeIdle;
                    state_q    <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign if_data_o   = if_data_q;
    assign if_ack_o    = if_ack_q;
    assign mem_rdata_o = mem_rdata_q;
    assign mem_ack_o   = mem_ack_q;
    assign sram_addr_o = sram_addr_q;
    assign sram_dout_o = sram_dout_q;
    assign sram_doe_o  = sram_doe_q;
    assign sram_ce_n_o = ce_n_q;
    assign sram_oe_n_o = oe_n_q;
    assign sram_we_n_o = we_n_q;

    assign if_stall_o  = if_req_i && !if_ack_q;
    assign mem_stall_o = (mem_rd_req_i || mem_wr_req_i) && !mem_ack_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios plus randomized transactions
// checked against a transaction-level latency/memory model.
module tb_mem_arbiter;

    localparam int unsigned RdW = 2;
    localparam int unsigned WrW = 2;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        if_req = 1'b0;
    logic [15:0] if_addr = '0;
    logic [15:0] if_data;
    logic        if_ack;
    logic        if_stall;
    logic        mem_rd_req = 1'b0;
    logic        mem_wr_req = 1'b0;
    logic [15:0] mem_addr = '0;
    logic [15:0] mem_wdata = '0;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic        mem_stall;
    logic [15:0] sram_addr;
    logic [15:0] sram_dout;
    logic        sram_doe;
    logic [15:0] sram_din;
    logic        sram_ce_n;
    logic        sram_oe_n;
    logic        sram_we_n;

    int checks = 0;
    int failures = 0;

    // SRAM model: contents written through the strobes, otherwise a fixed pattern.
    logic [15:0] sram [65536];
    bit          sram_w [65536];
    // Reference memory as the requesters expect to see it.
    logic [15:0] ref_mem [int];

    always #5 clk_i = ~clk_i;

    mem_arbiter #(
        .DataW  (16),
        .AddrW  (16),
        .RdWait (RdW),
        .WrWait (WrW)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .if_req_i     (if_req),
        .if_addr_i    (if_addr),
        .if_data_o    (if_data),
        .if_ack_o     (if_ack),
        .if_stall_o   (if_stall),
        .mem_rd_req_i (mem_rd_req),
        .mem_wr_req_i (mem_wr_req),
        .mem_addr_i   (mem_addr),
        .mem_wdata_i  (mem_wdata),
        .mem_rdata_o  (mem_rdata),
        .mem_ack_o    (mem_ack),
        .mem_stall_o  (mem_stall),
        .sram_addr_o  (sram_addr),
        .sram_dout_o  (sram_dout),
        .sram_doe_o   (sram_doe),
        .sram_din_i   (sram_din),
        .sram_ce_n_o  (sram_ce_n),
        .sram_oe_n_o  (sram_oe_n),
        .sram_we_n_o  (sram_we_n)
    );

    function automatic logic [15:0] init_val(input logic [15:0] a);
        if (a == 16'h0040) return 16'h1234;
        return {a[7:0], a[15:8]} ^ 16'hC3A5;
    endfunction

    function automatic logic [15:0] ref_rd(input logic [15:0] a);
        if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
        return init_val(a);
    endfunction

    assign sram_din = (!sram_ce_n && !sram_oe_n)
                      ? (sram_w[sram_addr] ? sram[sram_addr] : init_val(sram_addr)) : 16'h0000;

    always @(posedge clk_i) begin
        if (!sram_ce_n && !sram_we_n && sram_doe) begin
            sram[sram_addr]   = sram_dout;
            sram_w[sram_addr] = 1'b1;
        end
    end

    task automatic cyc();
        @(negedge clk_i);
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        cyc();
        #1;
        checks++;
        if ({sram_ce_n, sram_oe_n, sram_we_n, sram_doe} !== 4'b1110) begin
            failures++;
            $display("FAIL reset_strobes: got %b expected 1110",
                     {sram_ce_n, sram_oe_n, sram_we_n, sram_doe});
        end
        checks++;
        if ({sram_addr, sram_dout} !== 32'h0) begin
            failures++;
            $display("FAIL reset_bus: got %h expected 0", {sram_addr, sram_dout});
        end
        checks++;
        if ({if_ack, mem_ack, if_data, mem_rdata} !== 34'h0) begin
            failures++;
            $display("FAIL reset_acks: got %h expected 0", {if_ack, mem_ack, if_data, mem_rdata});
        end
        cyc();
        rst_ni = 1'b1;
    endtask

    task automatic test_reset_mid_write();
        int acks = 0;
        cyc();
        mem_wr_req = 1'b1;
        mem_addr   = 16'h7000;
        mem_wdata  = 16'hA5A5;
        cyc();
        #1;
        checks++;
        if (sram_we_n !== 1'b0) begin
            failures++;
            $display("FAIL midwr_we_low: got %b expected 0", sram_we_n);
        end
        #1;
        rst_ni = 1'b0;
        #1;
        checks++;
        if ({sram_we_n, sram_ce_n, sram_doe} !== 3'b110) begin
            failures++;
            $display("FAIL midwr_reset_strobes: got %b expected 110",
                     {sram_we_n, sram_ce_n, sram_doe});
        end
        mem_wr_req = 1'b0;
        cyc();
        rst_ni = 1'b1;
        for (int c = 0; c < 8; c++) begin
            cyc();
            #1;
            if (mem_ack === 1'b1) acks++;
        end
        checks++;
        if (acks != 0) begin
            failures++;
            $display("FAIL midwr_no_ack: got %0d acks expected 0", acks);
        end
        checks++;
        if (sram_w[16'h7000] !== 1'b0) begin
            failures++;
            $display("FAIL midwr_no_store: got %b expected 0", sram_w[16'h7000]);
        end
    endtask

    task automatic test_if_read();
        for (int c = 0; c <= 4; c++) begin
            cyc();
            if (c == 0) begin
                if_req  = 1'b1;
                if_addr = 16'h0040;
            end
            if (c == 4) if_req = 1'b0;
            #1;
            checks++;
            if (sram_oe_n !== ((c == 1 || c == 2) ? 1'b0 : 1'b1)) begin
                failures++;
                $display("FAIL ifrd_oe_n c%0d: got %b", c, sram_oe_n);
            end
            checks++;
            if (if_ack !== (c == 3)) begin
                failures++;
                $display("FAIL ifrd_ack c%0d: got %b expected %b", c, if_ack, c == 3);
            end
            checks++;
            if (if_stall !== (c <= 2)) begin
                failures++;
                $display("FAIL ifrd_stall c%0d: got %b expected %b", c, if_stall, c <= 2);
            end
            if (c == 3) begin
                checks++;
                if (if_data !== 16'h1234) begin
                    failures++;
                    $display("FAIL ifrd_data: got %h expected 1234", if_data);
                end
            end
        end
    endtask

    task automatic test_conflict();
        for (int c = 0; c <= 7; c++) begin
            cyc();
            if (c == 0) begin
                if_req     = 1'b1;
                if_addr    = 16'h0010;
                mem_rd_req = 1'b1;
                mem_addr   = 16'h8002;
            end
            if (c == 4) mem_rd_req = 1'b0;
            if (c == 7) if_req = 1'b0;
            #1;
            checks++;
            if (mem_ack !== (c == 3) || if_ack !== (c == 6)) begin
                failures++;
                $display("FAIL conf_acks c%0d: got mem=%b if=%b expected mem=%b if=%b",
                         c, mem_ack, if_ack, c == 3, c == 6);
            end
            checks++;
            if (if_stall !== (c <= 5)) begin
                failures++;
                $display("FAIL conf_if_stall c%0d: got %b expected %b", c, if_stall, c <= 5);
            end
            if (c == 1 || c == 2 || c == 4 || c == 5) begin
                checks++;
                if (sram_oe_n !== 1'b0 || sram_addr !== ((c < 3) ? 16'h8002 : 16'h0010)) begin
                    failures++;
                    $display("FAIL conf_addr c%0d: got oe_n=%b addr=%h", c, sram_oe_n, sram_addr);
                end
            end
            if (c == 3) begin
                checks++;
                if (mem_rdata !== ref_rd(16'h8002)) begin
                    failures++;
                    $display("FAIL conf_mem_data: got %h expected %h", mem_rdata, ref_rd(16'h8002));
                end
            end
            if (c == 6) begin
                checks++;
                if (if_data !== ref_rd(16'h0010)) begin
                    failures++;
                    $display("FAIL conf_if_data: got %h expected %h", if_data, ref_rd(16'h0010));
                end
            end
        end
    endtask

    task automatic test_write();
        for (int c = 0; c <= 5; c++) begin
            cyc();
            if (c == 0) begin
                mem_wr_req = 1'b1;
                mem_addr   = 16'h8000;
                mem_wdata  = 16'hBEEF;
            end
            if (c == 5) mem_wr_req = 1'b0;
            #1;
            checks++;
            if (sram_we_n !== ((c == 1 || c == 2) ? 1'b0 : 1'b1)) begin
                failures++;
                $display("FAIL wr_we_n c%0d: got %b", c, sram_we_n);
            end
            checks++;
            if (sram_doe !== (c >= 1 && c <= 3) || sram_ce_n !== !(c >= 1 && c <= 3)) begin
                failures++;
                $display("FAIL wr_doe_ce c%0d: got doe=%b ce_n=%b", c, sram_doe, sram_ce_n);
            end
            if (c >= 1 && c <= 3) begin
                checks++;
                if (sram_dout !== 16'hBEEF || sram_addr !== 16'h8000) begin
                    failures++;
                    $display("FAIL wr_bus c%0d: got %h@%h expected beef@8000", c, sram_dout, sram_addr);
                end
            end
            checks++;
            if (mem_ack !== (c == 4) || mem_stall !== (c <= 3)) begin
                failures++;
                $display("FAIL wr_ack_stall c%0d: got ack=%b stall=%b", c, mem_ack, mem_stall);
            end
        end
        ref_mem[16'h8000] = 16'hBEEF;
        checks++;
        if (sram[16'h8000] !== 16'hBEEF || !sram_w[16'h8000]) begin
            failures++;
            $display("FAIL wr_stored: got %h expected beef", sram[16'h8000]);
        end
    endtask

    task automatic test_rd_wr_both();
        int acks = 0;
        int oe_low = 0;
        int we_low = 0;
        int ack_c = -1;
        logic [15:0] wd = 16'($urandom);
        for (int c = 0; c <= 8; c++) begin
            cyc();
            if (c == 0) begin
                mem_rd_req = 1'b1;
                mem_wr_req = 1'b1;
                mem_addr   = 16'h8004;
                mem_wdata  = wd;
            end
            if (c == 5) begin
                mem_rd_req = 1'b0;
                mem_wr_req = 1'b0;
            end
            #1;
            if (mem_ack === 1'b1) begin
                acks++;
                ack_c = c;
            end
            if (sram_oe_n === 1'b0) oe_low++;
            if (sram_we_n === 1'b0) we_low++;
        end
        ref_mem[16'h8004] = wd;
        checks++;
        if (acks != 1 || ack_c != WrW + 2) begin
            failures++;
            $display("FAIL rdwr_ack: got %0d acks at c%0d expected 1 at c%0d", acks, ack_c, WrW + 2);
        end
        checks++;
        if (oe_low != 0 || we_low != WrW) begin
            failures++;
            $display("FAIL rdwr_strobes: got oe_low=%0d we_low=%0d expected 0 and %0d",
                     oe_low, we_low, WrW);
        end
        checks++;
        if (sram[16'h8004] !== wd) begin
            failures++;
            $display("FAIL rdwr_stored: got %h expected %h", sram[16'h8004], wd);
        end
    endtask

    task automatic test_if_rerequest();
        for (int c = 0; c <= 8; c++) begin
            cyc();
            if (c == 0) begin
                if_req  = 1'b1;
                if_addr = 16'h0100;
            end
            if (c == 4) if_addr = 16'h0102;
            if (c == 8) if_req = 1'b0;
            #1;
            checks++;
            if (sram_oe_n !== ((c == 1 || c == 2 || c == 5 || c == 6) ? 1'b0 : 1'b1)) begin
                failures++;
                $display("FAIL rereq_oe_n c%0d: got %b", c, sram_oe_n);
            end
            checks++;
            if (if_ack !== (c == 3 || c == 7)) begin
                failures++;
                $display("FAIL rereq_ack c%0d: got %b expected %b", c, if_ack, c == 3 || c == 7);
            end
            if (c == 7) begin
                checks++;
                if (if_data !== ref_rd(16'h0102)) begin
                    failures++;
                    $display("FAIL rereq_data: got %h expected %h", if_data, ref_rd(16'h0102));
                end
            end
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 40; t++) begin
            int kind = int'($urandom_range(0, 5));
            bit use_if  = (kind == 0 || kind >= 3);
            bit use_mrd = (kind == 1 || kind == 3 || kind == 5);
            bit use_mwr = (kind == 2 || kind == 4 || kind == 5);
            bit mem_on  = use_mrd || use_mwr;
            logic [15:0] ia = 16'h0200 + 16'($urandom_range(0, 15));
            logic [15:0] ma = 16'h0200 + 16'($urandom_range(0, 15));
            logic [15:0] wd = 16'($urandom);
            int mem_exp_c = use_mwr ? int'(WrW) + 2 : (use_mrd ? int'(RdW) + 1 : 0);
            int if_exp_c  = mem_exp_c + int'(RdW) + 1;
            logic [15:0] mem_exp_d = ref_rd(ma);
            logic [15:0] if_exp_d;
            bit mem_done = !mem_on;
            bit if_done  = !use_if;
            if (use_mwr) ref_mem[int'(ma)] = wd;
            if_exp_d = ref_rd(ia);
            for (int c = 0; c < 30 && !(mem_done && if_done); c++) begin
                cyc();
                if (c == 0) begin
                    if_req     = use_if;
                    if_addr    = ia;
                    mem_rd_req = use_mrd;
                    mem_wr_req = use_mwr;
                    mem_addr   = ma;
                    mem_wdata  = wd;
                end
                if (mem_done) begin
                    mem_rd_req = 1'b0;
                    mem_wr_req = 1'b0;
                end
                if (if_done) if_req = 1'b0;
                #1;
                if (mem_ack === 1'b1) begin
                    checks++;
                    if (mem_done || c != mem_exp_c) begin
                        failures++;
                        $display("FAIL rnd%0d_mem_ack: got ack at c%0d expected c%0d", t, c, mem_exp_c);
                    end
                    if (use_mrd && !use_mwr) begin
                        checks++;
                        if (mem_rdata !== mem_exp_d) begin
                            failures++;
                            $display("FAIL rnd%0d_mem_data: got %h expected %h", t, mem_rdata, mem_exp_d);
                        end
                    end
                    mem_done = 1'b1;
                end
                if (if_ack === 1'b1) begin
                    checks++;
                    if (if_done || c != if_exp_c || if_data !== if_exp_d) begin
                        failures++;
                        $display("FAIL rnd%0d_if: got c%0d data %h expected c%0d data %h",
                                 t, c, if_data, if_exp_c, if_exp_d);
                    end
                    if_done = 1'b1;
                end
            end
            checks++;
            if (!(mem_done && if_done)) begin
                failures++;
                $display("FAIL rnd%0d_timeout: got mem_done=%b if_done=%b expected both", t,
                         mem_done, if_done);
            end
            cyc();
            if_req     = 1'b0;
            mem_rd_req = 1'b0;
            mem_wr_req = 1'b0;
            repeat ($urandom_range(0, 2)) cyc();
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_write();
        test_if_read();
        test_conflict();
        test_write();
        test_rd_wr_both();
        test_if_rerequest();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
